// File: rtl/reg_file_pkg.sv
// Shared constants and the byte-lane merge used by the register write path and the write bypass.
package reg_file_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREG  = 32;
    localparam int NBYTE     = DEF_WIDTH / 8;

    // lane_merge works on a fixed wide vector; callers zero-extend in and truncate out.
    localparam int LM_W  = 1024;
    localparam int LM_NB = LM_W / 8;

    function automatic logic [LM_W-1:0] lane_merge(input logic [LM_W-1:0]  old_v,
                                                   input logic [LM_W-1:0]  new_v,
                                                   input logic [LM_NB-1:0] be);
        logic [LM_W-1:0] m;
        m = old_v;
        for (int i = 0; i < LM_NB; i++) begin
            if (be[i]) m[8*i +: 8] = new_v[8*i +: 8];
        end
        return m;
    endfunction
endpackage

// File: rtl/reg_file_be_reg.sv
// One WIDTH-bit register with asynchronous clear and per-byte load enables.
module reg_be
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               i_load,
    input  logic [WIDTH/8-1:0] i_be,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic [WIDTH-1:0]   o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_q <= '0;
        end else if (i_load && |i_be) begin
            r_q <= WIDTH'(lane_merge(LM_W'(r_q), LM_W'(i_wdata), LM_NB'(i_be)));
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/reg_file_be.sv
// Byte-enabled register file: one write port, two combinational read ports, optional hardwired r0.
// Define REG_FILE_WR_BYPASS_EN to forward a same-cycle write (lane-merged) onto a matching read port.
module reg_file_be
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREG     = DEF_NREG,
    parameter int AW       = (NREG > 1) ? $clog2(NREG) : 1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               Load,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]      raddr_a,
    output logic [WIDTH-1:0]   rdata_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_b
);
    logic [WIDTH-1:0] w_q [NREG];

    // Out-of-range write addresses never match any index, so they cannot alias.
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        if (ZERO_REG && g == 0) begin : g_zero
            assign w_q[g] = '0;
        end else begin : g_live
            logic w_sel;
            assign w_sel = Load && (waddr == AW'(g));
            reg_be #(.WIDTH(WIDTH)) u_reg (
                .clk     (clk),
                .clear   (clear),
                .i_load  (w_sel),
                .i_be    (wbe),
                .i_wdata (wdata),
                .o_q     (w_q[g])
            );
        end
    end

`ifdef REG_FILE_WR_BYPASS_EN
    logic w_fwd_ok;
    assign w_fwd_ok = !clear && Load && ({1'b0, waddr} < (AW+1)'(NREG))
                      && !(ZERO_REG && waddr == '0);
`endif

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (raddr_a == AW'(i)) rdata_a = w_q[i];
            if (raddr_b == AW'(i)) rdata_b = w_q[i];
        end
`ifdef REG_FILE_WR_BYPASS_EN
        // A matching read already holds the stored word of waddr; merge the new lanes over it.
        if (w_fwd_ok && raddr_a == waddr)
            rdata_a = WIDTH'(lane_merge(LM_W'(rdata_a), LM_W'(wdata), LM_NB'(wbe)));
        if (w_fwd_ok && raddr_b == waddr)
            rdata_b = WIDTH'(lane_merge(LM_W'(rdata_b), LM_W'(wdata), LM_NB'(wbe)));
`endif
    end
endmodule

// File: tb/tb_reg_file_be.sv
// Bench for reg_file_be: three configurations share one stimulus stream and are checked against an array model.
module tb_reg_file_be;
    logic        clk = 1'b0;
    logic        clear, Load;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [31:0] rda0, rdb0, rda1, rdb1, rda2, rdb2;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [3][32];
    int nreg_c [3] = '{32, 32, 24};
    bit zero_c [3] = '{1'b1, 1'b0, 1'b1};

`ifdef REG_FILE_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_file_be #(.WIDTH(32), .NREG(32), .ZERO_REG(1'b1)) u_d0 (
        .clk(clk), .clear(clear), .Load(Load), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rda0), .raddr_b(raddr_b), .rdata_b(rdb0));
    reg_file_be #(.WIDTH(32), .NREG(32), .ZERO_REG(1'b0)) u_d1 (
        .clk(clk), .clear(clear), .Load(Load), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rda1), .raddr_b(raddr_b), .rdata_b(rdb1));
    reg_file_be #(.WIDTH(32), .NREG(24), .ZERO_REG(1'b1)) u_d2 (
        .clk(clk), .clear(clear), .Load(Load), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rda2), .raddr_b(raddr_b), .rdata_b(rdb2));

    function automatic logic [31:0] get_a(int k);
        return (k == 0) ? rda0 : (k == 1) ? rda1 : rda2;
    endfunction

    function automatic logic [31:0] get_b(int k);
        return (k == 0) ? rdb0 : (k == 1) ? rdb1 : rdb2;
    endfunction

    // Reference read: what the register bank should show right now.
    function automatic logic [31:0] mread(int k, logic [4:0] a);
        logic [31:0] v;
        if (clear || int'(a) >= nreg_c[k] || (zero_c[k] && a == 5'd0)) return 32'd0;
        v = mem[k][a];
        if (BYPASS && Load && waddr == a) begin
            for (int b = 0; b < 4; b++) if (wbe[b]) v[8*b +: 8] = wdata[8*b +: 8];
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 32; r++) mem[k][r] = 32'd0;
    endtask

    task automatic model_commit();
        if (clear) begin
            model_clear();
        end else if (Load) begin
            for (int k = 0; k < 3; k++) begin
                if (int'(waddr) < nreg_c[k] && !(zero_c[k] && waddr == 5'd0)) begin
                    for (int b = 0; b < 4; b++)
                        if (wbe[b]) mem[k][waddr][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input logic ld, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic [4:0] ra, input logic [4:0] rb);
        Load = ld; waddr = wa; wdata = wd; wbe = be; raddr_a = ra; raddr_b = rb;
    endtask

    task automatic test_reset();
        logic [31:0] e_mid;
        clear = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 4'd0, 5'd0, 5'd0);
        model_clear();
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            #1;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (get_a(k) !== 32'd0 || get_b(k) !== 32'd0) begin
                    miscompares++;
                    $display("FAIL reset_zero dut%0d addr %0d: got %h/%h expected 0", k, i, get_a(k), get_b(k));
                end
            end
        end
        tick();
        clear = 1'b0;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd5);
        tick();
        Load = 1'b0;
        #1;
        vectors++;
        if (rda0 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL reset_prewrite: got %h expected deadbeef", rda0);
        end
        #2;
        clear = 1'b1;
        #1;
        vectors++;
        if (rda0 !== 32'd0 || rda1 !== 32'd0 || rda2 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %h/%h/%h expected 0", rda0, rda1, rda2);
        end
        tick();
        clear = 1'b0;
        drive(1'b1, 5'd5, 32'h12345678, 4'hF, 5'd5, 5'd6);
        tick();
        Load = 1'b0;
        #1;
        e_mid = 32'h12345678;
        vectors++;
        if (rda0 !== e_mid || rdb0 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_first_write: got %h/%h expected %h/0", rda0, rdb0, e_mid);
        end
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 5'd7, 32'h11223344, 4'hF, 5'd7, 5'd7);
        tick();
        drive(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 5'd7, 5'd7);
        tick();
        Load = 1'b0;
        #1;
        vectors++;
        if (rda0 !== 32'h11BB33DD || rdb1 !== 32'h11BB33DD || rda2 !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL byte_enable: got %h/%h/%h expected 11bb33dd", rda0, rdb1, rda2);
        end
        drive(1'b0, 5'd7, 32'hFFFFFFFF, 4'hF, 5'd7, 5'd7);
        tick();
        vectors++;
        if (rda0 !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL load_low_hold: got %h expected 11bb33dd", rda0);
        end
        drive(1'b1, 5'd7, 32'hFFFFFFFF, 4'h0, 5'd7, 5'd7);
        tick();
        Load = 1'b0;
        #1;
        vectors++;
        if (rdb0 !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL wbe_zero_hold: got %h expected 11bb33dd", rdb0);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0);
        tick();
        Load = 1'b0;
        #1;
        vectors++;
        if (rda0 !== 32'd0 || rdb2 !== 32'd0 || rda1 !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL zero_reg: got %h/%h/%h expected 0/0/ffffffff", rda0, rdb2, rda1);
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 5'd15, 32'h0F0F0F0F, 4'hF, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd23, 32'h5A5A5A5A, 4'hF, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd31, 32'h00000001, 4'hF, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd23, 5'd31);
        #1;
        vectors++;
        if (rda2 !== 32'h5A5A5A5A || rdb2 !== 32'd0 || rdb0 !== 32'h00000001) begin
            miscompares++;
            $display("FAIL out_of_range: got %h/%h/%h expected 5a5a5a5a/0/1", rda2, rdb2, rdb0);
        end
        raddr_b = 5'd15;
        #1;
        vectors++;
        if (rdb2 !== 32'h0F0F0F0F) begin
            miscompares++;
            $display("FAIL no_alias_r15: got %h expected 0f0f0f0f", rdb2);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] e_during;
        e_during = BYPASS ? 32'h0000F00D : 32'h00000010;
        drive(1'b1, 5'd3, 32'h00000010, 4'hF, 5'd3, 5'd3);
        tick();
        drive(1'b1, 5'd3, 32'hCAFEF00D, 4'b0011, 5'd3, 5'd3);
        #1;
        vectors++;
        if (rda0 !== e_during || rdb1 !== e_during || rda2 !== e_during) begin
            miscompares++;
            $display("FAIL same_cycle_read: got %h/%h/%h expected %h", rda0, rdb1, rda2, e_during);
        end
        tick();
        Load = 1'b0;
        #1;
        vectors++;
        if (rda0 !== 32'h0000F00D || rdb2 !== 32'h0000F00D) begin
            miscompares++;
            $display("FAIL after_edge_read: got %h/%h expected 0000f00d", rda0, rdb2);
        end
    endtask

    task automatic test_clear_collision();
        drive(1'b1, 5'd9, 32'h77777777, 4'hF, 5'd9, 5'd9);
        tick();
        drive(1'b1, 5'd9, 32'hFFFFFFFF, 4'hF, 5'd9, 5'd9);
        #2;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        Load = 1'b0;
        #1;
        vectors++;
        if (rda0 !== 32'd0 || rdb1 !== 32'd0) begin
            miscompares++;
            $display("FAIL clear_vs_load: got %h/%h expected 0", rda0, rdb1);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_v;
        for (int n = 0; n < 400; n++) begin
            clear = ($urandom_range(0, 49) == 0);
            drive(($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 4'($urandom), 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 2) == 0) raddr_a = waddr;
            if ($urandom_range(0, 3) == 0) raddr_b = waddr;
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_v = mread(k, raddr_a);
                vectors++;
                if (get_a(k) !== exp_v) begin
                    miscompares++;
                    $display("FAIL random_a n=%0d dut%0d addr %0d: got %h expected %h", n, k, raddr_a, get_a(k), exp_v);
                end
                exp_v = mread(k, raddr_b);
                vectors++;
                if (get_b(k) !== exp_v) begin
                    miscompares++;
                    $display("FAIL random_b n=%0d dut%0d addr %0d: got %h expected %h", n, k, raddr_b, get_b(k), exp_v);
                end
            end
            tick();
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_zero_reg();
        test_out_of_range();
        test_same_cycle();
        test_clear_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_file_be.md
Name: reg_file_be

Overview:
- Parametrised register bank and successor to the single 32-bit load register.
- Holds NREG words of WIDTH bits with one write port and two asynchronous read ports.
- Each write is qualified by a global Load strobe plus per-byte enables.
- Serves as the CPU datapath register file. Register 0 can be optionally hardwired to zero.

Parameters:
- WIDTH, 32, word width in bits; must be a multiple of 8.
- NREG, 32, number of registers; need not be a power of two.
- AW, $clog2(NREG), address width (derived; not overridden).
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset; zeroes every register.
- Load  input  1  write strobe; a write occurs only when high.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- wbe  input  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
- raddr_a  input  AW  read address, port A.
- rdata_a  output  WIDTH  read data, port A.
- raddr_b  input  AW  read address, port B.
- rdata_b  output  WIDTH  read data, port B.

Behaviour:
- Reset: clear high at any time → all registers 0 immediately, without waiting for a clock edge. rdata_a and rdata_b then read 0 combinationally. clear overrides Load on the same edge.
- Write: at posedge clk with clear=0, Load=1 and waddr<NREG, each byte lane i with wbe[i]=1 takes wdata lane i. Lanes with wbe[i]=0 hold their value. All other registers hold.
- Load=0 or wbe all-zero: no state change.
- waddr≥NREG: write ignored; no aliasing onto lower registers.
- ZERO_REG=1: writes to address 0 are ignored and register 0 reads 0. ZERO_REG=0: register 0 behaves like any other register.
- Read: purely combinational with zero latency. A read of raddr≥NREG returns 0.
- Write-to-read timing, without the optional feature: a write at edge k is visible on the read ports after edge k. A same-cycle read of waddr returns the pre-write value.
- Both read ports may address the same register, or the write register, simultaneously; no conflicts arise.
- If clear deasserts mid-cycle, the first write can occur at the next rising edge.

Optional Feature:
- Macro: REG_FILE_WR_BYPASS_EN.
- Defined: when Load=1, waddr<NREG, waddr==raddr_x, and the address is not the hardwired zero register, rdata_x returns a lane-merged value. Lanes with wbe=1 take wdata; lanes with wbe=0 take the stored value. This gives write-first semantics in the same cycle. The merged value is blocked while clear=1.
- Undefined: no forwarding; read-old semantics as above.

Decomposition:
- Package reg_file_pkg holds:
  - default WIDTH/NREG constants;
  - NBYTE=WIDTH/8;
  - a function lane_merge(old,new,be) used by both the write path and the bypass.
- Natural sub-module: reg_be, a single WIDTH-bit register with clk, clear, Load and byte enables. It is instantiated NREG times via generate, with the ZERO_REG entry tied to 0.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse clear mid-cycle → rdata_a(raddr=5)=0 before the next edge; all 32 registers read 0.
- Byte enables: r7=0x11223344, then write 0xAABBCCDD with wbe=4'b0101 → r7 reads 0x11BB33DD. A write with Load=0 and wbe=4'hF leaves it unchanged.
- Zero register: write 0xFFFFFFFF to r0 with ZERO_REG=1 → reads 0. Rebuild with ZERO_REG=0 → reads 0xFFFFFFFF.
- Dual read and out-of-range: NREG=24, write r23=0x5A5A5A5A and r31 (out of range) =0x1 → raddr_a=23 reads 0x5A5A5A5A, raddr_b=31 reads 0, r15 unchanged.
- Same-cycle read of the write address: r3=0x00000010, write 0xCAFEF00D with wbe=4'b0011 → during the write cycle rdata reads 0x00000010 without the macro, 0x0000F00D with REG_FILE_WR_BYPASS_EN. After the edge it reads 0x0000F00D in both builds.
- clear vs Load collision: Load=1 with waddr=9 on the edge where clear=1 → r9=0 after the edge.
